// File: rtl/press_gen_pkg.sv
// Shared types and helpers for the press pulse generator: channel state
// encoding and the period/width clamp applied when a config is captured.
package press_gen_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } chan_state_e;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] width;
    } pw_cfg_t;

    // Guarantees at least one low and one high cycle per period.
    function automatic pw_cfg_t clamp_cfg(input logic [31:0] period, input logic [31:0] width);
        pw_cfg_t c;
        c.period = (period < 32'd2) ? 32'd2 : period;
        c.width  = (width == 32'd0) ? 32'd1 : width;
        if (c.width >= c.period)
            c.width = c.period - 32'd1;
        return c;
    endfunction

endpackage

// File: rtl/press_chan.sv
// One pulse channel: IDLE/LOW/HIGH/DONE sequencer with a shadow config that
// is promoted to the active config only when a new period starts.
module press_chan
    import press_gen_pkg::*;
#(
    parameter int CNT_W      = 27,
    parameter int DEF_PERIOD = 200010,
    parameter int DEF_WIDTH  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_oneshot,
    input  logic             i_cfg_load,
    input  logic [CNT_W-1:0] i_cfg_period,
    input  logic [CNT_W-1:0] i_cfg_width,
    output logic             o_press,
    output logic             o_busy
);

    localparam pw_cfg_t          DEF_CFG = clamp_cfg(32'(DEF_PERIOD), 32'(DEF_WIDTH));
    localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEF_CFG.period);
    localparam logic [CNT_W-1:0] DEF_W   = CNT_W'(DEF_CFG.width);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    chan_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_act_p, r_act_w;
    logic [CNT_W-1:0] r_shd_p, r_shd_w;
    logic             r_press, r_busy;
    logic             w_act_load;
    logic             w_low_end, w_high_end;
    pw_cfg_t          w_cfg;

    assign w_cfg = clamp_cfg(32'(i_cfg_period), 32'(i_cfg_width));

    generate
        if (CNT_W < 32) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{w_cfg.period[31:CNT_W], w_cfg.width[31:CNT_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shd_p <= DEF_P;
            r_shd_w <= DEF_W;
        end else if (i_cfg_load) begin
            r_shd_p <= CNT_W'(w_cfg.period);
            r_shd_w <= CNT_W'(w_cfg.width);
        end
    end

    assign w_low_end  = (r_cnt == r_act_p - r_act_w - ONE);
    assign w_high_end = (r_cnt == r_act_w - ONE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_act_load  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                    w_act_load  = 1'b1;
                end
            end
            LOW: begin
                if (w_low_end) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            HIGH: begin
                if (w_high_end) begin
                    w_cnt_nxt = '0;
                    if (i_oneshot) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = LOW;
                        w_act_load  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
        // Dropping enable aborts from any state, truncating a pulse if needed.
        if (!i_enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_act_load  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_act_p <= DEF_P;
            r_act_w <= DEF_W;
            r_press <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_act_load) begin
                r_act_p <= r_shd_p;
                r_act_w <= r_shd_w;
            end
            r_press <= (w_state_nxt == HIGH);
            r_busy  <= (w_state_nxt == LOW) || (w_state_nxt == HIGH);
        end
    end

    assign o_press = r_press;
    assign o_busy  = r_busy;

endmodule

// File: rtl/press_pulse_gen.sv
// Multi-channel periodic press generator. Rising-edge pending flags and the
// irq line exist only when PRESS_PULSE_GEN_IRQ_EN is defined; otherwise tied 0.
module press_pulse_gen
    import press_gen_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 27,
    parameter int DEF_PERIOD = 200010,
    parameter int DEF_WIDTH  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] oneshot,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [NUM_CH-1:0] cfg_load,
    output logic [NUM_CH-1:0] press,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] irq_pend,
    input  logic [NUM_CH-1:0] irq_ack,
    output logic              irq
);

    logic [NUM_CH-1:0] w_press;
    logic [NUM_CH-1:0] w_busy;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
            press_chan #(
                .CNT_W      (CNT_W),
                .DEF_PERIOD (DEF_PERIOD),
                .DEF_WIDTH  (DEF_WIDTH)
            ) u_chan (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_enable     (enable[g]),
                .i_oneshot    (oneshot[g]),
                .i_cfg_load   (cfg_load[g]),
                .i_cfg_period (cfg_period),
                .i_cfg_width  (cfg_width),
                .o_press      (w_press[g]),
                .o_busy       (w_busy[g])
            );
        end
    endgenerate

    assign press = w_press;
    assign busy  = w_busy;

`ifdef PRESS_PULSE_GEN_IRQ_EN
    logic [NUM_CH-1:0] r_press_d;
    logic [NUM_CH-1:0] r_pend;

    // A new rising edge beats an ack arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press_d <= '0;
            r_pend    <= '0;
        end else begin
            r_press_d <= w_press;
            r_pend    <= (r_pend & ~irq_ack) | (w_press & ~r_press_d);
        end
    end

    assign irq_pend = r_pend;
    assign irq      = |r_pend;
`else
    logic w_unused_ack;
    assign w_unused_ack = ^irq_ack;
    assign irq_pend     = '0;
    assign irq          = 1'b0;
`endif

endmodule
